sfifo_axis_burst_reader: RTL and testbench

Drains a synchronous FIFO's read port and emits its contents as AXI-Stream packets. Each packet is a fixed-length burst, with TLAST on the final beat. If the FIFO holds a partial burst for too long, a programmable timeout flushes it as a short packet. The block sits directly on the read side of an asynchronous-read synchronous FIFO (data valid while not empty, pointer advances the cycle after a read strobe) and feeds a downstream AXI-Stream sink such as a DMA write channel.

---
 rtl/sfifo_axis_burst_reader_if.sv | 13 +
 rtl/sfifo_axis_burst_reader.sv | 133 +++++++++++++
 tb/tb_sfifo_axis_burst_reader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sfifo_axis_burst_reader_if.sv
// AXI-Stream bundle for the burst reader's output; the master drives
// TVALID/TDATA/TLAST and samples TREADY.
interface sfifo_axis_burst_reader_if #(
  parameter int BW = 32
) ();
  logic          tvalid;
  logic          tready;
  logic [BW-1:0] tdata;
  logic          tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/sfifo_axis_burst_reader.sv
// Drains an async-read synchronous FIFO into fixed-length AXI-Stream packets,
// flushing a lingering partial burst as a short packet after a timeout.
module sfifo_axis_burst_reader #(
  parameter int BW      = 32,
  parameter int LGFLEN  = 4,
  parameter int LGBURST = 4,
  parameter int TW      = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_fifo_empty,
  input  logic [BW-1:0]        i_fifo_data,
  input  logic [LGFLEN:0]      i_fifo_fill,
  output logic                 o_fifo_rd,
  input  logic [LGBURST:0]     i_burst_len,
  input  logic [TW-1:0]        i_timeout,
  sfifo_axis_burst_reader_if.master m_axis,
  output logic                 o_busy
);

  localparam int CW = ((LGFLEN > LGBURST) ? LGFLEN : LGBURST) + 1;
  localparam logic [LGBURST:0] MAX_LEN = {1'b1, {LGBURST{1'b0}}};
  localparam logic [LGBURST:0] ONE_LEN = (LGBURST+1)'(1);

  typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_e;

  state_e            state_q,  state_d;
  logic [LGBURST:0]  remain_q, remain_d;
  logic [TW-1:0]     timer_q,  timer_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q,  tlast_d;
  logic [BW-1:0]     tdata_q,  tdata_d;

  logic [LGBURST:0]  eff_len;
  logic [LGBURST:0]  partial_len;
  logic [CW-1:0]     fill_ext;
  logic [CW-1:0]     eff_ext;
  logic              fifo_rd;
  logic              handshake;

  always_comb begin
    if (i_burst_len == '0)          eff_len = ONE_LEN;
    else if (i_burst_len > MAX_LEN) eff_len = MAX_LEN;
    else                            eff_len = i_burst_len;
  end

  assign fill_ext    = CW'(i_fifo_fill);
  assign eff_ext     = CW'(eff_len);
  assign partial_len = (fill_ext < eff_ext) ? fill_ext[LGBURST:0] : eff_len;
  assign handshake   = tvalid_q && m_axis.tready;

  // NOTE: every variable gets its default first so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    timer_d  = timer_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    fifo_rd  = 1'b0;

    if (handshake) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (fill_ext >= eff_ext) begin
          remain_d = eff_len;
          timer_d  = '0;
          state_d  = BURST;
        end else if (i_fifo_fill != '0 && i_timeout != '0 && timer_q == i_timeout) begin
          remain_d = partial_len;
          timer_d  = '0;
          state_d  = BURST;
        end else if (i_fifo_fill == '0) begin
          timer_d = '0;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TW'(1);
        end
      end

      BURST: begin
        // A new beat may only replace the held one once it has been accepted.
        fifo_rd = !i_fifo_empty && (!tvalid_q || m_axis.tready) && remain_q != '0;
        if (fifo_rd) begin
          tdata_d  = i_fifo_data;
          tvalid_d = 1'b1;
          tlast_d  = (remain_q == ONE_LEN);
          remain_d = remain_q - ONE_LEN;
          if (remain_q == ONE_LEN) state_d = FLUSH;
        end
      end

      FLUSH: begin
        if (handshake && tlast_q) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    // NOTE: the data register is reset too, so TDATA reads 0 out of reset
    // rather than whatever the last abandoned beat held.
    if (i_reset) begin
      state_q  <= IDLE;
      remain_q <= '0;
      timer_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      timer_q  <= timer_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
    end
  end

  assign o_fifo_rd     = fifo_rd && !i_reset;
  assign o_busy        = (state_q != IDLE);
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tdata  = tdata_q;

endmodule

// File: tb/tb_sfifo_axis_burst_reader.sv
// Directed bench: a small async-read FIFO model feeds the reader; accepted
// beats are logged and compared against hand-computed packets and timings.
module tb_sfifo_axis_burst_reader;
  localparam int BW = 32, LGFLEN = 4, LGBURST = 4, TW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [LGBURST:0]   burst_len;
  logic [TW-1:0]      timeout;
  logic               fifo_empty;
  logic               fifo_rd;
  logic [BW-1:0]      fifo_data;
  logic [LGFLEN:0]    fifo_fill = '0;
  logic               busy;
  logic               wr_en = 1'b0;
  logic [BW-1:0]      wr_data = '0;

  sfifo_axis_burst_reader_if #(.BW(BW)) axis ();

  sfifo_axis_burst_reader #(.BW(BW), .LGFLEN(LGFLEN), .LGBURST(LGBURST), .TW(TW)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_fifo_empty (fifo_empty),
    .i_fifo_data  (fifo_data),
    .i_fifo_fill  (fifo_fill),
    .o_fifo_rd    (fifo_rd),
    .i_burst_len  (burst_len),
    .i_timeout    (timeout),
    .m_axis       (axis),
    .o_busy       (busy)
  );

  // FIFO model: head word visible while not empty, pointer moves after a read.
  logic [BW-1:0]     fmem [0:15];
  logic [LGFLEN-1:0] wptr = '0;
  logic [LGFLEN-1:0] rptr = '0;
  logic              pop;
  assign fifo_empty = (fifo_fill == '0);
  assign fifo_data  = fmem[rptr];
  assign pop        = fifo_rd && !fifo_empty;

  always @(posedge clk) begin
    if (wr_en) begin
      fmem[wptr] <= wr_data;
      wptr       <= wptr + 1'b1;
    end
    if (pop) rptr <= rptr + 1'b1;
    fifo_fill <= fifo_fill + (LGFLEN+1)'(wr_en) - (LGFLEN+1)'(pop);
  end

  logic [BW-1:0] beat_data [$];
  logic          beat_last [$];
  int            rd_count = 0;

  always @(posedge clk) begin
    if (!rst && axis.tvalid && axis.tready) begin
      beat_data.push_back(axis.tdata);
      beat_last.push_back(axis.tlast);
    end
    if (fifo_rd) rd_count <= rd_count + 1;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [BW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (!(fifo_fill == '0 && !busy && !axis.tvalid) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(n < budget), 64'd1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int rbase;

    rst         = 1'b1;
    burst_len   = 5'd4;
    timeout     = '0;
    axis.tready = 1'b1;
    repeat (3) tick();
    check("rst_tvalid", 64'(axis.tvalid), 64'd0);
    check("rst_tlast",  64'(axis.tlast),  64'd0);
    check("rst_tdata",  64'(axis.tdata),  64'd0);
    check("rst_busy",   64'(busy),        64'd0);
    check("rst_rd",     64'(fifo_rd),     64'd0);
    rst = 1'b0;
    tick();

    // Two full 4-beat packets from eight words.
    base  = beat_data.size();
    rbase = rd_count;
    for (int i = 0; i < 8; i++) push(BW'(32'h10 + i));
    drain("t1_drain", 60);
    check("t1_beats", 64'(beat_data.size() - base), 64'd8);
    check("t1_reads", 64'(rd_count - rbase), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check("t1_data", 64'(beat_data[base+i]), 64'(32'h10 + i));
      check("t1_last", 64'(beat_last[base+i]), 64'((i == 3) || (i == 7)));
    end

    // Timeout flush of a single word.
    timeout = 16'd8;
    push(32'hAA);
    repeat (8) tick();
    check("t2_idle_at_t",  64'(busy),    64'd0);
    check("t2_no_rd_at_t", 64'(fifo_rd), 64'd0);
    tick();
    check("t2_busy", 64'(busy),    64'd1);
    check("t2_rd",   64'(fifo_rd), 64'd1);
    tick();
    check("t2_tvalid", 64'(axis.tvalid), 64'd1);
    check("t2_tdata",  64'(axis.tdata),  64'hAA);
    check("t2_tlast",  64'(axis.tlast),  64'd1);
    tick();
    check("t2_done_busy",   64'(busy),        64'd0);
    check("t2_done_tvalid", 64'(axis.tvalid), 64'd0);
    timeout = '0;

    // Backpressure: TREADY alternates while a 4-beat burst drains 6 words.
    burst_len = 5'd16;
    for (int i = 0; i < 6; i++) push(BW'(32'h20 + i));
    burst_len = 5'd4;
    tick();
    check("t3_busy", 64'(busy),    64'd1);
    check("t3_rd0",  64'(fifo_rd), 64'd1);
    axis.tready = 1'b0;
    tick(); #1;
    check("t3_tvalid", 64'(axis.tvalid), 64'd1);
    check("t3_d0",     64'(axis.tdata),  64'h20);
    check("t3_stall0", 64'(fifo_rd),     64'd0);
    tick(); axis.tready = 1'b1; #1;
    check("t3_hold0", 64'(axis.tdata), 64'h20);
    check("t3_rd1",   64'(fifo_rd),    64'd1);
    tick(); axis.tready = 1'b0; #1;
    check("t3_d1",     64'(axis.tdata), 64'h21);
    check("t3_stall1", 64'(fifo_rd),    64'd0);
    tick(); axis.tready = 1'b1; #1;
    check("t3_hold1", 64'(axis.tdata), 64'h21);
    check("t3_rd2",   64'(fifo_rd),    64'd1);
    tick(); axis.tready = 1'b0; #1;
    check("t3_d2",     64'(axis.tdata), 64'h22);
    check("t3_stall2", 64'(fifo_rd),    64'd0);
    tick(); axis.tready = 1'b1; #1;
    check("t3_hold2", 64'(axis.tdata), 64'h22);
    check("t3_nlast", 64'(axis.tlast), 64'd0);
    check("t3_rd3",   64'(fifo_rd),    64'd1);
    tick(); axis.tready = 1'b0; #1;
    check("t3_d3",     64'(axis.tdata), 64'h23);
    check("t3_last",   64'(axis.tlast), 64'd1);
    check("t3_stall3", 64'(fifo_rd),    64'd0);
    check("t3_flush",  64'(busy),       64'd1);
    tick(); axis.tready = 1'b1; #1;
    check("t3_hold3", 64'(axis.tdata), 64'h23);
    tick();
    check("t3_idle",   64'(busy),        64'd0);
    check("t3_tvalid0", 64'(axis.tvalid), 64'd0);
    check("t3_fill",   64'(fifo_fill),   64'd2);

    // burst_len 0 acts as 1: the two leftover words leave as 1-beat packets.
    base      = beat_data.size();
    burst_len = 5'd0;
    drain("t4_drain", 40);
    check("t4_beats", 64'(beat_data.size() - base), 64'd2);
    check("t4_d0", 64'(beat_data[base]),   64'h24);
    check("t4_l0", 64'(beat_last[base]),   64'd1);
    check("t4_d1", 64'(beat_data[base+1]), 64'h25);
    check("t4_l1", 64'(beat_last[base+1]), 64'd1);

    // burst_len 31 clamps to 16: 15 words must not start a burst.
    burst_len = 5'd31;
    base      = beat_data.size();
    for (int i = 0; i < 15; i++) push(BW'(32'h40 + i));
    repeat (5) tick();
    check("t5_wait15", 64'(busy), 64'd0);
    push(32'h4F);
    drain("t5_drain", 80);
    check("t5_beats", 64'(beat_data.size() - base), 64'd16);
    for (int i = 0; i < 16; i++) begin
      check("t5_data", 64'(beat_data[base+i]), 64'(32'h40 + i));
      check("t5_last", 64'(beat_last[base+i]), 64'(i == 15));
    end

    // Length change mid-burst only affects the following packet.
    burst_len = 5'd16;
    base      = beat_data.size();
    for (int i = 0; i < 6; i++) push(BW'(32'h50 + i));
    burst_len = 5'd4;
    tick();
    tick();
    burst_len = 5'd2;
    drain("t6_drain", 60);
    check("t6_beats", 64'(beat_data.size() - base), 64'd6);
    for (int i = 0; i < 6; i++) begin
      check("t6_data", 64'(beat_data[base+i]), 64'(32'h50 + i));
      check("t6_last", 64'(beat_last[base+i]), 64'((i == 3) || (i == 5)));
    end

    // Reset after the second beat; leftovers flush on a fresh timer.
    burst_len = 5'd16;
    for (int i = 0; i < 4; i++) push(BW'(32'h60 + i));
    burst_len = 5'd4;
    tick();
    check("t7_rd0", 64'(fifo_rd), 64'd1);
    tick();
    check("t7_d0", 64'(axis.tdata), 64'h60);
    tick();
    check("t7_d1", 64'(axis.tdata), 64'h61);
    rst     = 1'b1;
    timeout = 16'd3;
    #1;
    check("t7_rd_in_rst", 64'(fifo_rd), 64'd0);
    tick();
    check("t7_tvalid", 64'(axis.tvalid), 64'd0);
    check("t7_tlast",  64'(axis.tlast),  64'd0);
    check("t7_tdata",  64'(axis.tdata),  64'd0);
    check("t7_busy",   64'(busy),        64'd0);
    check("t7_fill",   64'(fifo_fill),   64'd2);
    rst = 1'b0;
    repeat (3) tick();
    check("t7_wait_timer", 64'(busy), 64'd0);
    tick();
    check("t7_busy_after", 64'(busy),    64'd1);
    check("t7_rd_after",   64'(fifo_rd), 64'd1);
    tick();
    check("t7_p0",  64'(axis.tdata), 64'h62);
    check("t7_pl0", 64'(axis.tlast), 64'd0);
    tick();
    check("t7_p1",  64'(axis.tdata), 64'h63);
    check("t7_pl1", 64'(axis.tlast), 64'd1);
    drain("t7_drain", 20);
    timeout = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
